// File: rtl/uart_mmio_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_mmio_arbiter
// Purpose  : Shares one UART memory-side register port between two
//            requesters: m0 (core MMIO path) and m1 (debug/loader path).
//            Arbitration is round-robin. The grant stays locked until the
//            UART returns the completion pulse that matches the operation.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            mN_ren/raddr         - read request (held until mN_rvalid)
//            mN_rdata/rvalid      - read data / one-cycle read completion
//            mN_wen/waddr/wdata/wmask - write request (held until mN_wvalid)
//            mN_wvalid            - one-cycle write completion
//            s_*                  - UART-side request and completion signals
//            busy                 - a transaction is in flight
//            grant_id             - current or last granted master
//            err                  - one-cycle timeout pulse
// Options  : UART_ARB_TIMEOUT_EN - aborts a transaction after TIMEOUT busy
//            cycles. The aborted master receives all-ones read data and
//            err pulses. Without this macro, err is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module uart_mmio_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_ren,
  input  logic [ADDR_WIDTH-1:0]   m0_raddr,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  output logic                    m0_rvalid,
  input  logic                    m0_wen,
  input  logic [ADDR_WIDTH-1:0]   m0_waddr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_wmask,
  output logic                    m0_wvalid,
  input  logic                    m1_ren,
  input  logic [ADDR_WIDTH-1:0]   m1_raddr,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic                    m1_rvalid,
  input  logic                    m1_wen,
  input  logic [ADDR_WIDTH-1:0]   m1_waddr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_wmask,
  output logic                    m1_wvalid,
  output logic                    s_ren,
  output logic [ADDR_WIDTH-1:0]   s_raddr,
  output logic                    s_wen,
  output logic [ADDR_WIDTH-1:0]   s_waddr,
  output logic [DATA_WIDTH-1:0]   s_wdata,
  output logic [DATA_WIDTH/8-1:0] s_wmask,
  input  logic [DATA_WIDTH-1:0]   s_rdata,
  input  logic                    s_rvalid,
  input  logic                    s_wvalid,
  output logic                    busy,
  output logic                    grant_id,
  output logic                    err
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic                    grant_q, grant_d;
  logic                    op_wr_q, op_wr_d;

  logic                    s_ren_q, s_wen_q;
  logic [ADDR_WIDTH-1:0]   s_raddr_q, s_waddr_q;
  logic [DATA_WIDTH-1:0]   s_wdata_q;
  logic [MASK_WIDTH-1:0]   s_wmask_q;

  logic                    w_req0, w_req1;
  logic                    w_pick;
  logic                    w_pick_wen;
  logic                    w_grant_en;
  logic                    w_busy;
  logic                    w_done;
  logic                    w_timeout;
  logic                    w_finish;
  logic                    w_rd_cpl, w_wr_cpl;
  logic [DATA_WIDTH-1:0]   w_rdata;

  assign w_req0 = m0_ren | m0_wen;
  assign w_req1 = m1_ren | m1_wen;

  // When both masters request, the one that was not served last wins.
  // When only one requests, that master wins.
  assign w_pick     = (w_req0 & w_req1) ? ~grant_q : w_req1;
  // A write takes precedence over a simultaneous read from the same master.
  assign w_pick_wen = w_pick ? m1_wen : m0_wen;
  assign w_grant_en = (state_q == ST_IDLE) & (w_req0 | w_req1);

  assign w_busy   = (state_q == ST_BUSY);
  // Only a completion of the captured operation type ends the transaction.
  assign w_done   = w_busy & (op_wr_q ? s_wvalid : s_rvalid);
  assign w_finish = w_done | w_timeout;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (w_grant_en) begin
      cnt_q <= '0;
    end else if (w_busy) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // The counter holds k-1 in the k-th busy cycle, so the abort lands in
  // busy cycle TIMEOUT.
  assign w_timeout = w_busy & ~w_done & (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  logic w_timeout_unused;
  assign w_timeout_unused = (TIMEOUT != 0);
  assign w_timeout        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b1;   // m0 wins the first contested grant
      op_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      op_wr_q <= op_wr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    op_wr_d = op_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (w_req0 | w_req1) begin
          state_d = ST_BUSY;
          grant_d = w_pick;
          op_wr_d = w_pick_wen;
        end
      end
      ST_BUSY: begin
        if (w_finish) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The UART side sees a registered snapshot of the granted request. The
  // snapshot is frozen for the whole transaction, so a requester that
  // changes its inputs mid-flight cannot disturb the UART.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_ren_q   <= 1'b0;
      s_wen_q   <= 1'b0;
      s_raddr_q <= '0;
      s_waddr_q <= '0;
      s_wdata_q <= '0;
      s_wmask_q <= '0;
    end else if (w_grant_en) begin
      s_ren_q   <= ~w_pick_wen;
      s_wen_q   <= w_pick_wen;
      s_raddr_q <= w_pick ? m1_raddr : m0_raddr;
      s_waddr_q <= w_pick ? m1_waddr : m0_waddr;
      s_wdata_q <= w_pick ? m1_wdata : m0_wdata;
      s_wmask_q <= w_pick ? m1_wmask : m0_wmask;
    end else if (w_finish) begin
      s_ren_q <= 1'b0;
      s_wen_q <= 1'b0;
    end
  end

  assign s_ren   = s_ren_q;
  assign s_wen   = s_wen_q;
  assign s_raddr = s_raddr_q;
  assign s_waddr = s_waddr_q;
  assign s_wdata = s_wdata_q;
  assign s_wmask = s_wmask_q;

  // Completions are forwarded combinationally, and only to the granted master.
  assign w_rd_cpl = w_busy & ~op_wr_q & (s_rvalid | w_timeout);
  assign w_wr_cpl = w_busy &  op_wr_q & (s_wvalid | w_timeout);
  assign w_rdata  = w_timeout ? {DATA_WIDTH{1'b1}} : s_rdata;

  assign m0_rvalid = w_rd_cpl & ~grant_q;
  assign m1_rvalid = w_rd_cpl &  grant_q;
  assign m0_wvalid = w_wr_cpl & ~grant_q;
  assign m1_wvalid = w_wr_cpl &  grant_q;
  assign m0_rdata  = m0_rvalid ? w_rdata : '0;
  assign m1_rdata  = m1_rvalid ? w_rdata : '0;

  assign busy     = w_busy;
  assign grant_id = grant_q;
  assign err      = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_mmio_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_mmio_arbiter
// Purpose  : Self-checking bench for uart_mmio_arbiter. It runs directed
//            scenarios, then a randomized two-master run that is checked
//            against a round-robin grant model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_mmio_arbiter;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int MW  = DW / 8;
  localparam int TMO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          m0_ren, m0_wen, m1_ren, m1_wen;
  logic [AW-1:0] m0_raddr, m0_waddr, m1_raddr, m1_waddr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic [MW-1:0] m0_wmask, m1_wmask;
  logic          m0_rvalid, m0_wvalid, m1_rvalid, m1_wvalid;
  logic          s_ren, s_wen;
  logic [AW-1:0] s_raddr, s_waddr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [MW-1:0] s_wmask;
  logic          s_rvalid, s_wvalid;
  logic          busy, grant_id, err;

  int n_checks = 0;
  int n_pass   = 0;

  uart_mmio_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_ren(m0_ren), .m0_raddr(m0_raddr), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m0_wen(m0_wen), .m0_waddr(m0_waddr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_wvalid(m0_wvalid),
    .m1_ren(m1_ren), .m1_raddr(m1_raddr), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .m1_wen(m1_wen), .m1_waddr(m1_waddr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_wvalid(m1_wvalid),
    .s_ren(s_ren), .s_raddr(s_raddr), .s_wen(s_wen), .s_waddr(s_waddr),
    .s_wdata(s_wdata), .s_wmask(s_wmask), .s_rdata(s_rdata),
    .s_rvalid(s_rvalid), .s_wvalid(s_wvalid),
    .busy(busy), .grant_id(grant_id), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_ren = 0; m0_wen = 0; m0_raddr = '0; m0_waddr = '0; m0_wdata = '0; m0_wmask = '0;
    m1_ren = 0; m1_wen = 0; m1_raddr = '0; m1_waddr = '0; m1_wdata = '0; m1_wmask = '0;
    s_rdata = '0; s_rvalid = 0; s_wvalid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if ({busy, grant_id, err} !== 3'b010) $display("FAIL reset_status: busy/grant/err=%b expected 010", {busy, grant_id, err}); else n_pass++;
    n_checks++; if ({s_ren, s_wen} !== 2'b00 || {s_raddr, s_waddr, s_wdata, s_wmask} !== '0)
      $display("FAIL reset_s_side: ren=%b wen=%b raddr=%h waddr=%h wdata=%h wmask=%h expected all 0", s_ren, s_wen, s_raddr, s_waddr, s_wdata, s_wmask); else n_pass++;
    n_checks++; if ({m0_rvalid, m0_wvalid, m1_rvalid, m1_wvalid} !== 4'b0 || m0_rdata !== '0 || m1_rdata !== '0)
      $display("FAIL reset_m_side: valids=%b m0_rdata=%h m1_rdata=%h expected 0", {m0_rvalid, m0_wvalid, m1_rvalid, m1_wvalid}, m0_rdata, m1_rdata); else n_pass++;
    // Completions arriving while idle must be dropped.
    s_rvalid = 1; s_wvalid = 1; s_rdata = '1;
    #1;
    n_checks++; if ({m0_rvalid, m0_wvalid, m1_rvalid, m1_wvalid} !== 4'b0 || m0_rdata !== '0 || m1_rdata !== '0)
      $display("FAIL idle_completion: valids=%b rdata0=%h rdata1=%h expected 0", {m0_rvalid, m0_wvalid, m1_rvalid, m1_wvalid}, m0_rdata, m1_rdata); else n_pass++;
    tick();
    s_rvalid = 0; s_wvalid = 0; s_rdata = '0;
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_completion_busy: busy=%b expected 0", busy); else n_pass++;
  endtask

  task automatic test_single_read();
    logic early;
    m0_ren = 1; m0_raddr = 64'h1000_0005;
    tick();
    n_checks++; if ({s_ren, s_wen, busy, grant_id} !== 4'b1010 || s_raddr !== 64'h1000_0005)
      $display("FAIL read_issue: ren/wen/busy/grant=%b raddr=%h expected 1010 / 1000_0005", {s_ren, s_wen, busy, grant_id}, s_raddr); else n_pass++;
    early = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (m0_rvalid || m1_rvalid || m1_wvalid || m0_wvalid || !busy || !s_ren) early = 1;
    end
    n_checks++; if (early !== 1'b0) $display("FAIL read_wait: spurious valid or dropped request=%b expected 0", early); else n_pass++;
    tick();
    s_rvalid = 1; s_rdata = 64'h41;
    #1;
    n_checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 64'h41) $display("FAIL read_complete: m0_rvalid=%b m0_rdata=%h expected 1 / 41", m0_rvalid, m0_rdata); else n_pass++;
    n_checks++; if ({m1_rvalid, m1_wvalid, m0_wvalid} !== 3'b0 || m1_rdata !== '0)
      $display("FAIL read_other_quiet: m1 valids=%b m1_rdata=%h m0_wvalid=%b expected 0", {m1_rvalid, m1_wvalid}, m1_rdata, m0_wvalid); else n_pass++;
    tick();
    s_rvalid = 0; s_rdata = '0; m0_ren = 0;
    n_checks++; if ({s_ren, busy, m0_rvalid} !== 3'b000) $display("FAIL read_release: ren/busy/rvalid=%b expected 000", {s_ren, busy, m0_rvalid}); else n_pass++;
  endtask

  task automatic test_dual_write();
    do_reset();
    m0_wen = 1; m0_waddr = 64'hA0; m0_wdata = 64'h11; m0_wmask = 8'hFF;
    m1_wen = 1; m1_waddr = 64'hB0; m1_wdata = 64'h22; m1_wmask = 8'h0F;
    tick();
    n_checks++; if ({s_wen, s_ren, grant_id} !== 3'b100 || s_wdata !== 64'h11 || s_waddr !== 64'hA0)
      $display("FAIL dual_first: wen/ren/grant=%b wdata=%h waddr=%h expected 100 / 11 / A0", {s_wen, s_ren, grant_id}, s_wdata, s_waddr); else n_pass++;
    s_wvalid = 1;
    #1;
    n_checks++; if ({m0_wvalid, m1_wvalid} !== 2'b10) $display("FAIL dual_first_cpl: m0/m1 wvalid=%b expected 10", {m0_wvalid, m1_wvalid}); else n_pass++;
    tick();
    s_wvalid = 0; m0_wen = 0;
    n_checks++; if (s_wen !== 1'b0) $display("FAIL dual_gap: s_wen=%b expected 0", s_wen); else n_pass++;
    tick();
    n_checks++; if ({s_wen, grant_id} !== 2'b11 || s_wdata !== 64'h22 || s_wmask !== 8'h0F || s_waddr !== 64'hB0)
      $display("FAIL dual_second: wen/grant=%b wdata=%h wmask=%h waddr=%h expected 11 / 22 / 0F / B0", {s_wen, grant_id}, s_wdata, s_wmask, s_waddr); else n_pass++;
    s_wvalid = 1;
    #1;
    n_checks++; if ({m0_wvalid, m1_wvalid} !== 2'b01) $display("FAIL dual_second_cpl: m0/m1 wvalid=%b expected 01", {m0_wvalid, m1_wvalid}); else n_pass++;
    tick();
    s_wvalid = 0; m1_wen = 0;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL dual_end: busy=%b expected 0", busy); else n_pass++;
  endtask

  task automatic test_rr_stream();
    int  ng, cnt0, cnt1;
    bit  d0, d1, exp_g;
    do_reset();
    m0_raddr = 64'h100; m1_raddr = 64'h200;
    d0 = 0; d1 = 0; ng = 0; cnt0 = 0; cnt1 = 0;
    for (int cyc = 0; cyc < 100 && ng < 8; cyc++) begin
      m0_ren = ~d0; m1_ren = ~d1;
      s_rvalid = s_ren; s_rdata = 64'(cyc);
      if (s_ren) begin
        exp_g = (ng % 2) == 1;
        n_checks++; if (grant_id !== exp_g || s_raddr !== (exp_g ? 64'h200 : 64'h100))
          $display("FAIL rr_grant_%0d: grant=%b raddr=%h expected %b", ng, grant_id, s_raddr, exp_g); else n_pass++;
        if (grant_id) cnt1++; else cnt0++;
        ng++;
      end
      #1;
      d0 = m0_rvalid; d1 = m1_rvalid;
      tick();
    end
    m0_ren = 0; m1_ren = 0; s_rvalid = 0;
    tick();
    n_checks++; if (ng !== 8 || cnt0 !== 4 || cnt1 !== 4) $display("FAIL rr_totals: grants=%0d m0=%0d m1=%0d expected 8/4/4", ng, cnt0, cnt1); else n_pass++;
  endtask

  task automatic test_write_priority();
    m1_wen = 1; m1_ren = 1; m1_wdata = 64'hFF; m1_wmask = 8'h01; m1_waddr = 64'h30; m1_raddr = 64'h40;
    tick();
    n_checks++; if ({s_wen, s_ren, grant_id} !== 3'b101 || s_wdata !== 64'hFF || s_wmask !== 8'h01)
      $display("FAIL wpri_issue: wen/ren/grant=%b wdata=%h wmask=%h expected 101 / FF / 01", {s_wen, s_ren, grant_id}, s_wdata, s_wmask); else n_pass++;
    s_rvalid = 1;
    #1;
    n_checks++; if ({m1_rvalid, m1_wvalid} !== 2'b00) $display("FAIL wpri_wrong_type: rvalid/wvalid=%b expected 00", {m1_rvalid, m1_wvalid}); else n_pass++;
    tick();
    s_rvalid = 0;
    n_checks++; if (busy !== 1'b1) $display("FAIL wpri_still_busy: busy=%b expected 1", busy); else n_pass++;
    s_wvalid = 1;
    #1;
    n_checks++; if ({m1_rvalid, m1_wvalid} !== 2'b01) $display("FAIL wpri_cpl: rvalid/wvalid=%b expected 01", {m1_rvalid, m1_wvalid}); else n_pass++;
    tick();
    s_wvalid = 0; m1_wen = 0; m1_ren = 0;
    n_checks++; if ({s_wen, s_ren, busy} !== 3'b000) $display("FAIL wpri_release: wen/ren/busy=%b expected 000", {s_wen, s_ren, busy}); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_ren = 1; m0_raddr = 64'h55;
    tick();
    n_checks++; if ({busy, grant_id} !== 2'b10) $display("FAIL rstmid_busy: busy/grant=%b expected 10", {busy, grant_id}); else n_pass++;
    tick();
    rst = 1;
    tick();
    s_rvalid = 1;
    #1;
    n_checks++; if ({s_ren, busy, grant_id, m0_rvalid} !== 4'b0010)
      $display("FAIL rstmid_state: ren/busy/grant/rvalid=%b expected 0010", {s_ren, busy, grant_id, m0_rvalid}); else n_pass++;
    rst = 0; m0_ren = 0; s_rvalid = 0;
    tick();
  endtask

  task automatic test_timeout();
    logic bad;
    do_reset();
    m0_ren = 1; m0_raddr = 64'h77;
    bad = 0;
`ifdef UART_ARB_TIMEOUT_EN
    for (int k = 1; k <= TMO; k++) begin
      tick();
      if (k < TMO) begin
        if (m0_rvalid || err || !busy) bad = 1;
      end else begin
        n_checks++; if ({m0_rvalid, err} !== 2'b11 || m0_rdata !== '1)
          $display("FAIL tmo_abort: rvalid/err=%b rdata=%h expected 11 / all ones", {m0_rvalid, err}, m0_rdata); else n_pass++;
      end
    end
    n_checks++; if (bad !== 1'b0) $display("FAIL tmo_early: early abort=%b expected 0", bad); else n_pass++;
    m0_ren = 0;
    tick();
    n_checks++; if ({busy, err, s_ren} !== 3'b000) $display("FAIL tmo_idle: busy/err/ren=%b expected 000", {busy, err, s_ren}); else n_pass++;
`else
    for (int k = 1; k <= 3 * TMO; k++) begin
      tick();
      if (m0_rvalid || err || !busy) bad = 1;
    end
    n_checks++; if (bad !== 1'b0) $display("FAIL no_tmo_wait: abort or err seen=%b expected 0", bad); else n_pass++;
    do_reset();
`endif
  endtask

  task automatic test_random();
    bit            act[2], fin[2], twen[2], tren[2], prev_req[2];
    int            gap[2], left[2];
    logic [AW-1:0] taddr[2];
    logic [DW-1:0] tdata[2];
    logic [MW-1:0] tmask[2];
    logic          obs_rv[2], obs_wv[2];
    logic [DW-1:0] obs_rd[2];
    bit            last_g, own, sbusy, swr, pulse, exp_rv, exp_wv;
    int            sdelay, ndone;
    do_reset();
    last_g = 1; own = 0; sbusy = 0; swr = 0; sdelay = 0; ndone = 0;
    for (int n = 0; n < 2; n++) begin
      act[n] = 0; fin[n] = 0; twen[n] = 0; tren[n] = 0; prev_req[n] = 0;
      gap[n] = 0; left[n] = 20; taddr[n] = '0; tdata[n] = '0; tmask[n] = '0;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (left[0] == 0 && left[1] == 0 && !act[0] && !act[1] && !sbusy) break;
      s_rvalid = 0; s_wvalid = 0; s_rdata = '0; pulse = 0;
      // New UART transaction: the winner follows from who requested last cycle.
      if ((s_ren || s_wen) && !sbusy) begin
        own = (prev_req[0] && prev_req[1]) ? ~last_g : prev_req[1];
        n_checks++; if (grant_id !== own) $display("FAIL rnd_grant: grant=%b expected %b", grant_id, own); else n_pass++;
        n_checks++; if ({s_wen, s_ren} !== {twen[own], tren[own] & ~twen[own]})
          $display("FAIL rnd_op: wen/ren=%b expected %b", {s_wen, s_ren}, {twen[own], tren[own] & ~twen[own]}); else n_pass++;
        n_checks++;
        if (twen[own] ? ({s_waddr, s_wdata, s_wmask} !== {taddr[own], tdata[own], tmask[own]}) : (s_raddr !== taddr[own]))
          $display("FAIL rnd_payload: raddr=%h waddr=%h wdata=%h wmask=%h expected addr=%h data=%h mask=%h",
                   s_raddr, s_waddr, s_wdata, s_wmask, taddr[own], tdata[own], tmask[own]);
        else n_pass++;
        last_g = own; sbusy = 1; swr = twen[own]; sdelay = $urandom_range(0, 3);
      end
      if (sbusy) begin
        if (sdelay == 0) begin
          pulse = 1; sbusy = 0;
          if (swr) s_wvalid = 1;
          else begin s_rvalid = 1; s_rdata = {$urandom, $urandom}; end
        end else begin
          sdelay--;
          if ($urandom_range(0, 3) == 0) begin
            if (swr) s_rvalid = 1; else s_wvalid = 1;
          end
        end
      end
      #1;
      obs_rv[0] = m0_rvalid; obs_wv[0] = m0_wvalid; obs_rd[0] = m0_rdata;
      obs_rv[1] = m1_rvalid; obs_wv[1] = m1_wvalid; obs_rd[1] = m1_rdata;
      for (int n = 0; n < 2; n++) begin
        exp_rv = pulse && (own == n[0]) && !swr;
        exp_wv = pulse && (own == n[0]) && swr;
        n_checks++; if ({obs_rv[n], obs_wv[n]} !== {exp_rv, exp_wv})
          $display("FAIL rnd_valid_m%0d: rvalid/wvalid=%b expected %b", n, {obs_rv[n], obs_wv[n]}, {exp_rv, exp_wv}); else n_pass++;
        n_checks++; if (obs_rd[n] !== (exp_rv ? s_rdata : '0))
          $display("FAIL rnd_rdata_m%0d: rdata=%h expected %h", n, obs_rd[n], (exp_rv ? s_rdata : '0)); else n_pass++;
      end
      // Masters keep requesting through their valid cycle, drop for at least one cycle, then maybe start again.
      for (int n = 0; n < 2; n++) begin
        if (fin[n]) begin
          act[n] = 0; fin[n] = 0; gap[n] = $urandom_range(0, 2);
        end else if (act[n]) begin
          if (pulse && own == n[0]) begin fin[n] = 1; ndone++; end
        end else begin
          if (gap[n] > 0) gap[n]--;
          else if (left[n] > 0) begin
            twen[n]  = $urandom_range(0, 1) == 1;
            tren[n]  = !twen[n] || ($urandom_range(0, 3) == 0);
            taddr[n] = {$urandom, $urandom};
            tdata[n] = {$urandom, $urandom};
            tmask[n] = MW'($urandom);
            act[n] = 1; left[n]--;
          end
        end
      end
      m0_ren = act[0] & tren[0]; m0_wen = act[0] & twen[0];
      m0_raddr = taddr[0]; m0_waddr = taddr[0]; m0_wdata = tdata[0]; m0_wmask = tmask[0];
      m1_ren = act[1] & tren[1]; m1_wen = act[1] & twen[1];
      m1_raddr = taddr[1]; m1_waddr = taddr[1]; m1_wdata = tdata[1]; m1_wmask = tmask[1];
      prev_req[0] = act[0]; prev_req[1] = act[1];
      tick();
    end
    clear_inputs();
    tick();
    n_checks++; if (ndone !== 40 || busy !== 1'b0) $display("FAIL rnd_totals: completions=%0d busy=%b expected 40 / 0", ndone, busy); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_dual_write();
    test_rr_stream();
    test_write_priority();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_mmio_arbiter.md
Name: uart_mmio_arbiter

Overview:
- Two-requester arbiter sharing one UART memory-side port (ren/raddr/rdata/rvalid, wen/waddr/wdata/wmask/wvalid) between the core MMIO path (m0) and the debug/loader path (m1).
- Round-robin grant, locked until the UART returns the valid pulse. Sits between the AXI-lite-to-mem bridges and the UART register block.

Parameters:
- ADDR_WIDTH, 64, address width of all ports.
- DATA_WIDTH, 64, data width; the mask width is DATA_WIDTH/8.
- TIMEOUT, 1024, cycles the arbiter waits for a slave valid pulse before aborting; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- mN_ren  in  1  read request, held until mN_rvalid (N = 0,1)
- mN_raddr  in  ADDR_WIDTH  read address
- mN_rdata  out  DATA_WIDTH  read data, valid when mN_rvalid is high
- mN_rvalid  out  1  one-cycle read completion
- mN_wen  in  1  write request, held until mN_wvalid
- mN_waddr  in  ADDR_WIDTH  write address
- mN_wdata  in  DATA_WIDTH  write data
- mN_wmask  in  DATA_WIDTH/8  byte mask
- mN_wvalid  out  1  one-cycle write completion
- s_ren, s_wen  out  1  UART-side requests
- s_raddr, s_waddr  out  ADDR_WIDTH  UART-side addresses
- s_wdata  out  DATA_WIDTH  UART-side write data
- s_wmask  out  DATA_WIDTH/8  UART-side byte mask
- s_rdata  in  DATA_WIDTH  UART read data
- s_rvalid, s_wvalid  in  1  UART completions
- busy  out  1  a transaction is in flight
- grant_id  out  1  current or last granted master
- err  out  1  timeout pulse; always 0 without the optional feature

Behaviour:
- FSM states: IDLE and BUSY.
- Reset state: IDLE, grant_id=1 (so m0 wins first), busy=0, err=0, all s_* outputs 0, all mN_rvalid/mN_wvalid 0, mN_rdata 0.
- Master request: req_N = mN_ren | mN_wen.
- IDLE arbitration:
  - If exactly one req_N is high, grant that master.
  - If both are high, grant the master that is not grant_id.
  - On a grant: register grant_id, register op (write if mN_wen else read), then go to BUSY.
  - If mN_ren and mN_wen are both high in the same cycle, the write is served and the read is ignored.
- BUSY:
  - Drive the s_* signals from registered copies of the granted master's request. These are captured at grant and held stable for the whole transaction.
  - Latency: a request sampled in cycle 0 appears on s_ren/s_wen in cycle 1.
  - s_rvalid or s_wvalid (matching the op) is passed combinationally to the granted master's mN_rvalid/mN_wvalid in the same cycle. s_rdata passes through to mN_rdata of the granted master only.
  - On the completion cycle, next state is IDLE and s_ren/s_wen drop in the next cycle.
  - A completion of the wrong type, or one arriving in IDLE, is ignored and never forwarded.
- Back-to-back requests:
  - A master must drop its request the cycle after its valid.
  - A request still high in the IDLE cycle that follows is a new request.
  - Minimum spacing between transactions is 2 cycles, and fairness holds under continuous load.
- Non-granted master: outputs stay 0 and its request is held pending, with no loss.
- busy = (state == BUSY).
- Reset mid-transaction: return to IDLE, drop s_ren/s_wen the next cycle, emit no valid.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT-1 with no completion, the arbiter issues mN_rvalid/mN_wvalid to the granted master (mN_rdata = all ones), pulses err for 1 cycle, and goes to IDLE.
- Without the macro: no counter, err is tied 0, and BUSY waits indefinitely.

Test Plan:
- m0 read, raddr=0x1000_0005, UART returns s_rvalid 3 cycles after s_ren with s_rdata=0x41 -> s_ren high cycle 1; m0_rvalid=1 and m0_rdata=0x41 in the cycle of s_rvalid; m1 outputs stay 0.
- m0 and m1 both write in the same cycle from reset (wdata 0x11, 0x22) -> m0 is served first; m1's s_wen rises 2 cycles after m0_wvalid with s_wdata=0x22; grant_id 0 then 1.
- Both masters stream continuous reads for 8 transactions -> grants alternate 0,1,0,1,… with 4 each.
- m1 asserts wen and ren together, wdata=0xFF, wmask=0x01 -> only s_wen is driven and s_ren stays 0; m1_wvalid returns.
- rst asserted 2 cycles into BUSY -> the next cycle s_ren=0, busy=0, no valid, grant_id=1.
- With UART_ARB_TIMEOUT_EN and TIMEOUT=16, the UART never responds -> m0_rvalid=1, m0_rdata=all ones, and err=1 at BUSY cycle 16; FSM back in IDLE.
